// File: rtl/adc_avg_pkg.sv
// Shared types and Q16.16 constants for the ADC window averager.
// Optional build macro: ADC_AVG_CAL_EN enables the calibration multiply.
package adc_avg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DRAIN
  } state_t;

  localparam logic [31:0] GAIN_ONE = 32'h0001_0000;
  localparam int ROUND_HALF = 'h8000;
  localparam int FRAC_BITS = 16;

  // Wide enough for 2^max_log2 full-scale samples of adc_w bits.
  function automatic int acc_width(input int adc_w, input int max_log2);
    return adc_w + max_log2;
  endfunction

endpackage

// File: rtl/adc_cal_scale.sv
// Stages 2-3 of the sample path: gain multiply, round, saturate.
// ADC_AVG_CAL_EN undefined: samples pass through, SAT stays 0.
module adc_cal_scale
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int GAIN_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ADC_WIDTH-1:0] sample,
  input  logic                        tag_in,
  input  logic [GAIN_WIDTH-1:0]       gain,
  output logic signed [ADC_WIDTH-1:0] scaled,
  output logic                        tag_out,
  output logic                        sat
);

  localparam int PW = ADC_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [ADC_WIDTH-1:0] MAXC =
    {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] MINC =
    {1'b1, {(ADC_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic                 tag2;

`ifdef ADC_AVG_CAL_EN
  logic signed [PW-1:0] rnd;
  logic                 ovf_hi;
  logic                 ovf_lo;

  always_comb begin
    rnd    = (prod + PW'(ROUND_HALF)) >>> FRAC_BITS;
    ovf_hi = rnd > PW'(MAXC);
    ovf_lo = rnd < PW'(MINC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod    <= '0;
      tag2    <= 1'b0;
      scaled  <= '0;
      tag_out <= 1'b0;
      sat     <= 1'b0;
    end else begin
      prod    <= PW'(sample) * PW'($signed({1'b0, gain}));
      tag2    <= tag_in;
      tag_out <= tag2;
      sat     <= ovf_hi | ovf_lo;
      if (ovf_hi)
        scaled <= MAXC;
      else if (ovf_lo)
        scaled <= MINC;
      else
        scaled <= rnd[ADC_WIDTH-1:0];
    end
  end
`else
  wire unused_ok = ^{gain, prod[PW-1:ADC_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod    <= '0;
      tag2    <= 1'b0;
      scaled  <= '0;
      tag_out <= 1'b0;
      sat     <= 1'b0;
    end else begin
      prod    <= PW'(sample);
      tag2    <= tag_in;
      tag_out <= tag2;
      scaled  <= prod[ADC_WIDTH-1:0];
      sat     <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/adc_window_average.sv
// Windowed ADC averager: settle, capture 2^LOG2_LEN samples, emit mean.
// Optional build macro: ADC_AVG_CAL_EN (Q16.16 gain in adc_cal_scale).
module adc_window_average
  import adc_avg_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int GAIN_WIDTH = 32,
  parameter int MAX_LOG2   = 12
) (
  input  logic                  ADC_CLK,
  input  logic                  ADC_RST,
  input  logic                  START,
  input  logic [ADC_WIDTH-1:0]  ADC_DATA_IN,
  input  logic [31:0]           SETTLE_CYCLES,
  input  logic [4:0]            LOG2_LEN,
  input  logic [GAIN_WIDTH-1:0] CAL_GAIN,
  output logic [ADC_WIDTH-1:0]  AVG_OUT,
  output logic                  AVG_VALID,
  output logic                  BUSY,
  output logic                  SAT
);

  localparam int ACC_W = acc_width(ADC_WIDTH, MAX_LOG2);
  localparam int CW    = MAX_LOG2 + 1;

  state_t state, state_next;

  logic [31:0]           settle_cnt;
  logic [4:0]            log2_q;
  logic [4:0]            log2_in;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [CW-1:0]         cap_cnt;
  logic [CW-1:0]         cap_last;
  logic [1:0]            drain_cnt;
  logic                  accept;
  logic                  finish;

  logic signed [ADC_WIDTH-1:0] s1;
  logic                        s1_tag;
  logic signed [ADC_WIDTH-1:0] s3;
  logic                        s3_tag;
  logic                        s3_sat;
  logic signed [ACC_W-1:0]     acc;
  logic                        sat_win;

  assign log2_in  = (LOG2_LEN > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : LOG2_LEN;
  assign cap_last = (CW'(1) << log2_q) - CW'(1);
  assign BUSY     = state != IDLE;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        accept = START;
        if (START)
          state_next = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      end
      SETTLE:
        if (settle_cnt == 32'd1)
          state_next = CAPTURE;
      CAPTURE:
        if (cap_cnt == cap_last)
          state_next = DRAIN;
      DRAIN: begin
        // Four edges: three pipeline stages plus the final accumulate.
        finish = drain_cnt == 2'd3;
        if (finish)
          state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ADC_CLK or posedge ADC_RST) begin
    if (ADC_RST) begin
      state      <= IDLE;
      settle_cnt <= '0;
      log2_q     <= '0;
      gain_q     <= GAIN_WIDTH'(GAIN_ONE);
      cap_cnt    <= '0;
      drain_cnt  <= '0;
      s1         <= '0;
      s1_tag     <= 1'b0;
      acc        <= '0;
      sat_win    <= 1'b0;
      AVG_OUT    <= '0;
      AVG_VALID  <= 1'b0;
      SAT        <= 1'b0;
    end else begin
      state     <= state_next;
      s1        <= ADC_DATA_IN;
      s1_tag    <= state == CAPTURE;
      AVG_VALID <= finish;
      if (accept) begin
        settle_cnt <= SETTLE_CYCLES;
        log2_q     <= log2_in;
        gain_q     <= CAL_GAIN;
        cap_cnt    <= '0;
        drain_cnt  <= '0;
        acc        <= '0;
        sat_win    <= 1'b0;
      end else begin
        if (state == SETTLE)
          settle_cnt <= settle_cnt - 32'd1;
        if (state == CAPTURE)
          cap_cnt <= cap_cnt + CW'(1);
        if (state == DRAIN)
          drain_cnt <= drain_cnt + 2'd1;
        if (s3_tag) begin
          acc     <= acc + ACC_W'(s3);
          sat_win <= sat_win | s3_sat;
        end
      end
      if (finish) begin
        AVG_OUT <= ADC_WIDTH'(acc >>> log2_q);
        SAT     <= sat_win;
      end
    end
  end

  adc_cal_scale #(
    .ADC_WIDTH (ADC_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH)
  ) u_scale (
    .clk    (ADC_CLK),
    .rst    (ADC_RST),
    .sample (s1),
    .tag_in (s1_tag),
    .gain   (gain_q),
    .scaled (s3),
    .tag_out(s3_tag),
    .sat    (s3_sat)
  );

endmodule
